uop_fetch_queue: RTL

Microcode sequencer and issue buffer upstream of `microcode_exec`. It walks a program counter over the microcode store, fetches up to two 32-bit uops per cycle into an 8-entry circular queue, and presents up to two uops per cycle to the execute stage. Execute uses `take` to report how many it accepted. Execute can also redirect the program counter, which flushes the queue.

---
 rtl/leg_uop_pkg.sv | 17 +
 rtl/uop_queue.sv | 82 ++++++++
 rtl/uop_fetch_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/leg_uop_pkg.sv
// leg_uop_pkg
// Types and constants shared by the microcode fetch path and microcode_exec.
//   uop_t         : one 32-bit microcode word
//   HALT_UOP      : sentinel word that stops fetch and is never enqueued
//   fetch_state_t : fetch sequencer state (RUN fetches, HALT only drains)
package leg_uop_pkg;

  typedef logic [31:0] uop_t;

  localparam uop_t HALT_UOP = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/uop_queue.sv
// uop_queue
// 2-write / 2-read circular buffer holding fetched uops together with the
// store address each uop came from.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   flush               : empty the queue (wins over wr_n and rd_n)
//   wr_n                : number of entries written at the tail (0..2)
//   wr_data0/1, wr_pc0/1: uops and their addresses for tail and tail+1
//   rd_n                : number of entries retired from the head (0..2)
//   rd_data0/1, rd_pc0/1: head and head+1 contents
//   level               : current occupancy
module uop_queue
  import leg_uop_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int PC_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [1:0]                wr_n,
  input  logic [31:0]               wr_data0,
  input  logic [31:0]               wr_data1,
  input  logic [PC_W-1:0]           wr_pc0,
  input  logic [PC_W-1:0]           wr_pc1,
  input  logic [1:0]                rd_n,
  output logic [31:0]               rd_data0,
  output logic [31:0]               rd_data1,
  output logic [PC_W-1:0]           rd_pc0,
  output logic [PC_W-1:0]           rd_pc1,
  output logic [$clog2(QDEPTH):0]   level
);

  localparam int PW = $clog2(QDEPTH);

  uop_t            mem    [QDEPTH];
  logic [PC_W-1:0] pc_mem [QDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;

  // Pointers are exactly log2(QDEPTH) wide, so +1 wraps modulo QDEPTH.
  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  assign rd_data0 = mem[head];
  assign rd_data1 = mem[head_p1];
  assign rd_pc0   = pc_mem[head];
  assign rd_pc1   = pc_mem[head_p1];

  // Storage is cleared on reset so the head outputs read as zero until
  // the first fetch lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (wr_n != 2'd0) begin
        mem[tail]    <= wr_data0;
        pc_mem[tail] <= wr_pc0;
      end
      if (wr_n == 2'd2) begin
        mem[tail_p1]    <= wr_data1;
        pc_mem[tail_p1] <= wr_pc1;
      end
      tail  <= tail + PW'(wr_n);
      head  <= head + PW'(rd_n);
      level <= level + (PW+1)'(wr_n) - (PW+1)'(rd_n);
    end
  end

endmodule

// File: rtl/uop_fetch_queue.sv
// uop_fetch_queue
// Microcode sequencer plus issue buffer: walks pc over the microcode store,
// enqueues up to two uops per cycle and presents up to two to execute.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   uops                      : microcode store, read combinationally
//   redirect_valid/redirect_pc: flush the queue and restart fetch
//   out_uop0/1, out_pc0/1     : queue head and head+1 with their addresses
//   out_count                 : valid head entries, min(level, 2)
//   take                      : uops accepted by execute (clamped to out_count)
//   level                     : queue occupancy
//   halted                    : fetch has stopped
module uop_fetch_queue
  import leg_uop_pkg::*;
#(
  parameter int UOP_DEPTH = 129,
  parameter int PC_W      = 8,
  parameter int QDEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             uops [UOP_DEPTH],
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic [31:0]             out_uop0,
  output logic [31:0]             out_uop1,
  output logic [PC_W-1:0]         out_pc0,
  output logic [PC_W-1:0]         out_pc1,
  output logic [1:0]              out_count,
  input  logic [1:0]              take,
  output logic [$clog2(QDEPTH):0] level,
  output logic                    halted
);

  localparam int LW = $clog2(QDEPTH) + 1;
  localparam logic [PC_W:0] DEPTH_C = (PC_W+1)'(UOP_DEPTH);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;

  logic [PC_W:0]   addr0;
  logic [PC_W:0]   addr1;
  logic [PC_W:0]   pc_adv;
  logic [LW-1:0]   free;
  uop_t            word0;
  uop_t            word1;
  logic [1:0]      wr_n;
  logic            halt_det;
  logic [1:0]      take_eff;
  logic [1:0]      q_wr_n;
  logic [1:0]      q_rd_n;

  // Addresses carry one extra bit so pc+1 past the store end is visible.
  assign addr0 = {1'b0, pc};
  assign addr1 = addr0 + (PC_W+1)'(1);

  // Free space comes from the registered level only; a same-cycle take
  // does not make room for this cycle's fetch.
  assign free = LW'(QDEPTH) - level;

  // Out-of-store addresses read as the halt sentinel so they are never
  // enqueued.
  assign word0 = (addr0 < DEPTH_C) ? uops[pc] : HALT_UOP;
  assign word1 = (addr1 < DEPTH_C) ? uops[addr1[PC_W-1:0]] : HALT_UOP;

  // Decide how many uops to write this cycle and whether fetch must stop:
  // a halt word in either slot, or pc reaching the end of the store.
  always_comb begin
    wr_n     = 2'd0;
    halt_det = 1'b0;
    if (state == RUN && free != '0) begin
      if (word0 == HALT_UOP) begin
        halt_det = 1'b1;
      end else begin
        wr_n = 2'd1;
        if (free >= LW'(2)) begin
          if (word1 == HALT_UOP) begin
            halt_det = 1'b1;
          end else begin
            wr_n = 2'd2;
          end
        end
      end
    end
    pc_adv = addr0 + (PC_W+1)'(wr_n);
    if (state == RUN && pc_adv >= DEPTH_C) begin
      halt_det = 1'b1;
    end
  end

  // Execute may over-report take; clamp to what is actually presented.
  // Redirect discards both the fetch and the take of its cycle.
  assign out_count = (level >= LW'(2)) ? 2'd2 : level[1:0];
  assign take_eff  = (take > out_count) ? out_count : take;
  assign q_wr_n    = redirect_valid ? 2'd0 : wr_n;
  assign q_rd_n    = redirect_valid ? 2'd0 : take_eff;

  // Fetch sequencer: redirect restarts from redirect_pc (straight into
  // HALT when that is outside the store); RUN advances pc by the number
  // of uops written and drops to HALT when a stop condition is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      pc     <= '0;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if ({1'b0, redirect_pc} >= DEPTH_C) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        state  <= RUN;
        halted <= 1'b0;
      end
    end else if (state == RUN) begin
      pc <= pc_adv[PC_W-1:0];
      if (halt_det) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

  uop_queue #(
    .QDEPTH (QDEPTH),
    .PC_W   (PC_W)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .wr_n     (q_wr_n),
    .wr_data0 (word0),
    .wr_data1 (word1),
    .wr_pc0   (addr0[PC_W-1:0]),
    .wr_pc1   (addr1[PC_W-1:0]),
    .rd_n     (q_rd_n),
    .rd_data0 (out_uop0),
    .rd_data1 (out_uop1),
    .rd_pc0   (out_pc0),
    .rd_pc1   (out_pc1),
    .level    (level)
  );

endmodule
